le_prefix_builder: RTL
======================

# le_prefix_builder

Active-prefix builder for the low-entropy path of the hybrid entropy coder. It accepts one low-entropy symbol per handshake and keeps a separate active prefix for each of the 16 code indices. It appends each symbol to the selected prefix and presents the candidate prefix to the shared combinational codebook lookup (the codebook_bN_f family behind an index mux). On a codebook match it emits the codeword and clears that prefix; at end of image it flushes every non-empty prefix to the downstream flush-table stage.

## Interface
- CODEBOOK_LENGTH_MAX, 64, prefix width in bits (4-bit nibbles, max 16 symbols)
- ENCODE_DATALENGTH, 21, codeword width
- NUM_CODES, 16, number of code indices / prefix registers
- clk_i  in  1  single clock, rising edge
- rst_n_i  in  1  reset, asynchronous, active-low
- sym_valid_i  in  1  symbol valid
- sym_ready_o  out  1  symbol accepted when valid&ready
- sym_index_i  in  4  code index of symbol
- sym_value_i  in  4  symbol value, 0..L_i, or 4'hF = escape X
- flush_i  in  1  end-of-image flush request, single-cycle pulse
- cb_index_o  out  4  code index to codebook mux
- ap_cnt_o  out  6  candidate prefix symbol count
- ap_data_o  out  64  candidate prefix, newest symbol in nibble [3:0]
- cb_match_i  in  1  codebook match (combinational from ap_*_o)
- cb_length_i  in  6  matched codeword length
- cb_data_i  in  21  matched codeword, right-aligned
- cw_valid_o / cw_ready_i  out/in  1  codeword handshake
- cw_length_o  out  6, cw_data_o  out  21  codeword
- fl_valid_o / fl_ready_i  out/in  1  flush-record handshake
- fl_index_o  out  4, fl_cnt_o  out  6, fl_data_o  out  64  flushed prefix
- flush_done_o  out  1  one-cycle pulse after the flush scan completes
- err_overflow_o  out  1  sticky, a prefix reached 16 symbols without a match

## Operation
- Storage: per index, ap_cnt[i] (0..16) and ap_data[i] (64b). All are zero after reset.
- FSM states: IDLE, LOOKUP, EMIT, FLUSH_SCAN, FLUSH_EMIT.
- sym_ready_o = (state==IDLE) && !flush_pend.
- flush_pend is set by flush_i in any state. It is cleared on entry to FLUSH_SCAN.
- IDLE, symbol accepted:
  - cand_data = (ap_data[idx] << 4) | sym_value_i, truncated to 64b.
  - cand_cnt = ap_cnt[idx] + 1; cand_idx = idx.
  - Next state is LOOKUP.
- IDLE with flush_pend: next state is FLUSH_SCAN with scan_idx=0. Flush has priority over a simultaneous symbol, because sym_ready_o is 0 in that case.
- LOOKUP:
  - Outputs: ap_cnt_o=cand_cnt, ap_data_o=cand_data, cb_index_o=cand_idx.
  - On cb_match_i: latch cw_length/cw_data, clear prefix[cand_idx], go to EMIT.
  - Else if cand_cnt==16: clear prefix[cand_idx], set err_overflow_o, go to IDLE. No codeword is emitted.
  - Else: write cand back to prefix[cand_idx], go to IDLE.
- In all states other than LOOKUP, ap_cnt_o=0, ap_data_o=0 and cb_index_o=0. Count 0 never matches.
- EMIT: cw_valid_o=1 with cw_length_o and cw_data_o held stable until cw_ready_i, then go to IDLE.
- FLUSH_SCAN:
  - If ap_cnt[scan_idx]!=0: load the fl_* registers and go to FLUSH_EMIT.
  - Else if scan_idx==15: pulse flush_done_o and go to IDLE.
  - Else: increment scan_idx.
- FLUSH_EMIT:
  - fl_valid_o=1 until fl_ready_i.
  - On the handshake: clear prefix[scan_idx].
  - Then, if scan_idx==15, pulse flush_done_o and go to IDLE; otherwise increment scan_idx and go to FLUSH_SCAN.
- Flush order is ascending index. Empty prefixes produce no record.
- A flush_i arriving during a flush is latched and runs a second scan afterwards; an immediate second scan produces only flush_done_o.

## Timing
- Reset:
  - State is IDLE.
  - All registered outputs are 0: cw_valid_o, fl_valid_o, flush_done_o, err_overflow_o, and all data/length/cnt outputs.
  - sym_ready_o=1 from the first cycle after rst_n_i deasserts.
- Reset mid-operation: everything clears asynchronously, including all prefixes and flush_pend. Any pending codeword or flush record is dropped.
- Symbol accepted on edge T:
  - LOOKUP during cycle T+1.
  - cw_valid_o high from T+2 on a match.
  - sym_ready_o high at T+2 on no match, or in the cycle after the cw handshake.
- Throughput: 1 symbol per 2 cycles without a match, 3 cycles minimum per symbol that completes a codeword.
- The codebook path is combinational within LOOKUP and adds no latency. ap_*_o are driven from registers.
- Flush: 1 cycle per empty index and at least 2 cycles per non-empty index. flush_done_o is a single cycle.
- Backpressure: cw_* and fl_* are held unchanged while valid&&!ready.

## Test plan
- Index 7, symbol F → cw_valid_o at T+2 with cw_length_o=10, cw_data_o=0x3F6; prefix 7 empty afterwards.
- Index 7, symbols 1, 0, F → no codeword after 1 or 0; after F, length 14, data 0x3FF4. Index 7, symbols 0, F → length 11, data 0x7F2.
- Interleaving: index 7 receives 1, index 3 receives 0 then 2 (stub codebook, no match), then flush_i → fl records {3, 2, 0x02} then {7, 1, 0x1}, then flush_done_o; all ap_cnt become 0.
- cw_ready_i held low 5 cycles during EMIT → cw_* stable, sym_ready_o=0, no symbol lost; release → single handshake.
- Never-match stub, 16 symbols of 0 on index 0 → err_overflow_o=1 at the 16th LOOKUP and stays 1; prefix 0 cleared; no cw_valid_o.
- rst_n_i pulsed low during EMIT and during FLUSH_EMIT → outputs 0 immediately; a subsequent flush produces only flush_done_o.

Source files
------------

// File: rtl/le_prefix_builder.sv
// le_prefix_builder: per-index active-prefix builder with codebook lookup, codeword emit and end-of-image flush
module le_prefix_builder #(
  parameter int CODEBOOK_LENGTH_MAX = 64,
  parameter int ENCODE_DATALENGTH   = 21,
  parameter int NUM_CODES           = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           sym_valid_i,
  output logic                           sym_ready_o,
  input  logic [3:0]                     sym_index_i,
  input  logic [3:0]                     sym_value_i,
  input  logic                           flush_i,
  output logic [3:0]                     cb_index_o,
  output logic [5:0]                     ap_cnt_o,
  output logic [CODEBOOK_LENGTH_MAX-1:0] ap_data_o,
  input  logic                           cb_match_i,
  input  logic [5:0]                     cb_length_i,
  input  logic [ENCODE_DATALENGTH-1:0]   cb_data_i,
  output logic                           cw_valid_o,
  input  logic                           cw_ready_i,
  output logic [5:0]                     cw_length_o,
  output logic [ENCODE_DATALENGTH-1:0]   cw_data_o,
  output logic                           fl_valid_o,
  input  logic                           fl_ready_i,
  output logic [3:0]                     fl_index_o,
  output logic [5:0]                     fl_cnt_o,
  output logic [CODEBOOK_LENGTH_MAX-1:0] fl_data_o,
  output logic                           flush_done_o,
  output logic                           err_overflow_o
);
  typedef enum logic [2:0] {IDLE, LOOKUP, EMIT, FLUSH_SCAN, FLUSH_EMIT} state_t;
  state_t state_q, state_d;
  logic [4:0]                     ap_cnt_q  [NUM_CODES];
  logic [CODEBOOK_LENGTH_MAX-1:0] ap_data_q [NUM_CODES];
  logic [4:0]                     cand_cnt_q;
  logic [CODEBOOK_LENGTH_MAX-1:0] cand_data_q;
  logic [3:0]                     cand_idx_q, scan_idx_q;
  logic                           flush_pend_q, flush_done_q, err_q;
  logic [5:0]                     cw_length_q, fl_cnt_q;
  logic [ENCODE_DATALENGTH-1:0]   cw_data_q;
  logic [3:0]                     fl_index_q;
  logic [CODEBOOK_LENGTH_MAX-1:0] fl_data_q;
  logic accept, lookup, scan_nz, scan_last, fl_hs, wr_en;
  logic [3:0] wr_idx;
  logic [4:0] wr_cnt;
  logic [CODEBOOK_LENGTH_MAX-1:0] wr_data;
  assign accept    = sym_valid_i && sym_ready_o;
  assign lookup    = state_q == LOOKUP;
  assign scan_nz   = ap_cnt_q[scan_idx_q] != 5'd0;
  assign scan_last = scan_idx_q == 4'd15;
  assign fl_hs     = state_q == FLUSH_EMIT && fl_ready_i;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       state_d = flush_pend_q ? FLUSH_SCAN : sym_valid_i ? LOOKUP : IDLE;
      LOOKUP:     state_d = cb_match_i ? EMIT : IDLE;
      EMIT:       state_d = cw_ready_i ? IDLE : EMIT;
      FLUSH_SCAN: state_d = scan_nz ? FLUSH_EMIT : scan_last ? IDLE : FLUSH_SCAN;
      FLUSH_EMIT: state_d = !fl_ready_i ? FLUSH_EMIT : scan_last ? IDLE : FLUSH_SCAN;
      default:    state_d = IDLE;
    endcase
  end
  always_comb begin
    sym_ready_o    = state_q == IDLE && !flush_pend_q;
    cw_valid_o     = state_q == EMIT;
    fl_valid_o     = state_q == FLUSH_EMIT;
    ap_cnt_o       = lookup ? {1'b0, cand_cnt_q} : 6'd0;
    ap_data_o      = lookup ? cand_data_q : '0;
    cb_index_o     = lookup ? cand_idx_q : 4'd0;
    cw_length_o    = cw_length_q;
    cw_data_o      = cw_data_q;
    fl_index_o     = fl_index_q;
    fl_cnt_o       = fl_cnt_q;
    fl_data_o      = fl_data_q;
    flush_done_o   = flush_done_q;
    err_overflow_o = err_q;
  end
  // Single prefix write port: LOOKUP writes back or clears the candidate, a flush handshake clears the scanned entry.
  always_comb begin
    wr_en   = lookup || fl_hs;
    wr_idx  = lookup ? cand_idx_q : scan_idx_q;
    wr_cnt  = lookup && !cb_match_i && cand_cnt_q != 5'd16 ? cand_cnt_q : 5'd0;
    wr_data = lookup && !cb_match_i && cand_cnt_q != 5'd16 ? cand_data_q : '0;
  end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      for (int i = 0; i < NUM_CODES; i++) begin
        ap_cnt_q[i]  <= '0;
        ap_data_q[i] <= '0;
      end
    end else if (wr_en) begin
      ap_cnt_q[wr_idx]  <= wr_cnt;
      ap_data_q[wr_idx] <= wr_data;
    end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      cand_cnt_q   <= '0;
      cand_data_q  <= '0;
      cand_idx_q   <= '0;
      scan_idx_q   <= '0;
      flush_pend_q <= 1'b0;
      flush_done_q <= 1'b0;
      err_q        <= 1'b0;
      cw_length_q  <= '0;
      cw_data_q    <= '0;
      fl_index_q   <= '0;
      fl_cnt_q     <= '0;
      fl_data_q    <= '0;
    end else begin
      // A pending flush is consumed only when IDLE launches the scan, so requests during a scan queue a rescan.
      flush_pend_q <= flush_i || (flush_pend_q && state_q != IDLE);
      flush_done_q <= (state_q == FLUSH_SCAN && !scan_nz && scan_last) || (fl_hs && scan_last);
      if (accept) begin
        cand_idx_q  <= sym_index_i;
        cand_cnt_q  <= ap_cnt_q[sym_index_i] + 5'd1;
        cand_data_q <= {ap_data_q[sym_index_i][CODEBOOK_LENGTH_MAX-5:0], sym_value_i};
      end
      if (lookup && cb_match_i) begin
        cw_length_q <= cb_length_i;
        cw_data_q   <= cb_data_i;
      end
      if (lookup && !cb_match_i && cand_cnt_q == 5'd16) err_q <= 1'b1;
      if (state_q == IDLE && flush_pend_q) scan_idx_q <= 4'd0;
      else if ((state_q == FLUSH_SCAN && !scan_nz && !scan_last) || (fl_hs && !scan_last))
        scan_idx_q <= scan_idx_q + 4'd1;
      if (state_q == FLUSH_SCAN && scan_nz) begin
        fl_index_q <= scan_idx_q;
        fl_cnt_q   <= {1'b0, ap_cnt_q[scan_idx_q]};
        fl_data_q  <= ap_data_q[scan_idx_q];
      end
    end
endmodule
